// File: rtl/pico_pkg.sv
// Shared FSM type and R/W-word constants for the PICO serial receive front end.
package pico_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DROP
  } pico_state_t;

  localparam logic PICO_RW_WRITE = 1'b1;

  // The R/W flag is always the MSB of the first word, whatever the word width.
  function automatic int pico_rw_bit(input int word_w);
    return word_w - 1;
  endfunction

endpackage

// File: rtl/pico_edge_sync.sv
// Pad synchroniser: STAGES flops on clock and data, registered rising-edge detect; data is
// presented aligned with its edge pulse, STAGES+1 cycles after the pad; no backpressure.
module pico_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_clk,
  input  logic pad_dat,
  output logic rise,
  output logic dat
);

  logic [STAGES-1:0] clk_sync;
  logic [STAGES-1:0] dat_sync;
  logic              clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      rise     <= 1'b0;
      dat      <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[STAGES-2:0], pad_clk};
      dat_sync <= {dat_sync[STAGES-2:0], pad_dat};
      clk_prev <= clk_sync[STAGES-1];
      rise     <= clk_sync[STAGES-1] & ~clk_prev;
      dat      <= dat_sync[STAGES-1];
    end
  end

endmodule

// File: rtl/pico_spi_rx.sv
// PICO serial receive front end: R/W + start address word, then wr_en/rd_req one iclk after each
// data word on a wrapping auto-increment address; no backpressure. Optional parity: PICO_PARITY_EN.
module pico_spi_rx
  import pico_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 128,
  parameter int TIMEOUT     = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              serial_in,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_en,
  output logic              rd_req,
  output logic              busy,
  output logic              timeout_pulse,
  output logic              addr_err,
  output logic              parity_err
);

`ifdef PICO_PARITY_EN
  localparam int LAST_BIT = WORD_W;
`else
  localparam int LAST_BIT = WORD_W - 1;
`endif
  localparam int SHIFT_W = LAST_BIT;
  localparam int CNT_W   = $clog2(WORD_W + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int RW_BIT  = pico_rw_bit(WORD_W);
  localparam logic [ADDR_W:0]   NUM_REGS_V = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  pico_state_t        state, state_next;
  logic               sample_en, sample_bit;
  logic [SHIFT_W-1:0] shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               rw;
  logic [WORD_W-1:0]  word;
  logic               word_ok, word_done, start_ok, timeout_hit;
  logic [ADDR_W-1:0]  start, addr_inc;

  pico_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (iclk),
    .rst     (rst),
    .pad_clk (sclk),
    .pad_dat (serial_in),
    .rise    (sample_en),
    .dat     (sample_bit)
  );

`ifdef PICO_PARITY_EN
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign word    = shift;
  assign word_ok = ^{shift, sample_bit};
`else
  assign word    = {shift, sample_bit};
  assign word_ok = 1'b1;
`endif

  assign busy        = (state != IDLE);
  assign word_done   = sample_en && (bit_cnt == CNT_W'(LAST_BIT));
  assign start       = word[ADDR_W-1:0];
  assign start_ok    = ({1'b0, start} < NUM_REGS_V);
  assign addr_inc    = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
  // Fires on the cycle the idle count would reach TIMEOUT; a same-cycle sample always wins.
  assign timeout_hit = !sample_en && (busy || bit_cnt != '0) &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (sample_en) state_next = ADDR;
        ADDR:    if (word_done) state_next = (word_ok && start_ok) ? DATA : DROP;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      rw            <= 1'b0;
      addr          <= '0;
      wr_data       <= '0;
      wr_en         <= 1'b0;
      rd_req        <= 1'b0;
      timeout_pulse <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      state         <= state_next;
      wr_en         <= 1'b0;
      rd_req        <= 1'b0;
      timeout_pulse <= 1'b0;
      addr_err      <= 1'b0;
      if (wr_en) addr <= addr_inc;
      if (sample_en) begin
        idle_cnt <= '0;
        shift    <= {shift[SHIFT_W-2:0], sample_bit};
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
      end else if (timeout_hit) begin
        idle_cnt      <= '0;
        bit_cnt       <= '0;
        shift         <= '0;
        timeout_pulse <= 1'b1;
      end else if (busy || bit_cnt != '0) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (word_done && word_ok) begin
        case (state)
          ADDR: begin
            rw <= word[RW_BIT];
            if (start_ok) begin
              addr   <= start;
              rd_req <= (word[RW_BIT] != PICO_RW_WRITE);
            end else begin
              addr_err <= 1'b1;
            end
          end
          DATA: begin
            if (rw == PICO_RW_WRITE) begin
              wr_en   <= 1'b1;
              wr_data <= word;
            end else begin
              addr   <= addr_inc;
              rd_req <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PICO_PARITY_EN
  always_ff @(posedge iclk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= word_done && !word_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pico_spi_rx.sv
// Bench for pico_spi_rx: two instances (128 and 64 registers) share one randomised pad stream and
// are scored event-by-event against a transaction-level model of the register protocol.
module tb_pico_spi_rx;

  localparam int TIMEOUT = 7;
  localparam int SYNC    = 2;
  localparam int NR_A    = 128;
  localparam int NR_B    = 64;

  localparam logic [3:0] EV_W = 4'd1;
  localparam logic [3:0] EV_R = 4'd2;
  localparam logic [3:0] EV_E = 4'd3;
  localparam logic [3:0] EV_T = 4'd4;
  localparam logic [3:0] EV_P = 4'd5;

  logic iclk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic serial_in = 1'b0;

  logic [6:0] addr_a, addr_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic wr_en_a, rd_req_a, busy_a, timeout_pulse_a, addr_err_a, parity_err_a;
  logic wr_en_b, rd_req_b, busy_b, timeout_pulse_b, addr_err_b, parity_err_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  logic [19:0] exp_a[$];
  logic [19:0] exp_b[$];
  logic [6:0]  m_addr[2];
  logic [7:0]  m_wdata[2];
  logic [7:0]  words[8];
  bit          badp[8];

  pico_spi_rx #(.NUM_REGS(NR_A)) dut_a (
    .iclk(iclk), .rst(rst), .sclk(sclk), .serial_in(serial_in),
    .addr(addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a), .rd_req(rd_req_a),
    .busy(busy_a), .timeout_pulse(timeout_pulse_a), .addr_err(addr_err_a),
    .parity_err(parity_err_a)
  );

  pico_spi_rx #(.NUM_REGS(NR_B)) dut_b (
    .iclk(iclk), .rst(rst), .sclk(sclk), .serial_in(serial_in),
    .addr(addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .rd_req(rd_req_b),
    .busy(busy_b), .timeout_pulse(timeout_pulse_b), .addr_err(addr_err_b),
    .parity_err(parity_err_b)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  function automatic int pend(input int d);
    return (d == 0) ? exp_a.size() : exp_b.size();
  endfunction
  function automatic logic [6:0] got_addr(input int d);
    return (d == 0) ? addr_a : addr_b;
  endfunction
  function automatic logic [7:0] got_wdata(input int d);
    return (d == 0) ? wr_data_a : wr_data_b;
  endfunction
  function automatic logic got_busy(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [20:0] got_all(input int d);
    if (d == 0)
      return {addr_a, wr_data_a, wr_en_a, rd_req_a, busy_a, timeout_pulse_a, addr_err_a, parity_err_a};
    return {addr_b, wr_data_b, wr_en_b, rd_req_b, busy_b, timeout_pulse_b, addr_err_b, parity_err_b};
  endfunction

  // Scoreboard: every output pulse must match the next event the model predicted for that instance.
  always @(negedge iclk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        logic [4:0]  hits;
        logic [19:0] ev, e;
        int          lat;
        hits = (d == 0) ? {parity_err_a, timeout_pulse_a, addr_err_a, rd_req_a, wr_en_a}
                        : {parity_err_b, timeout_pulse_b, addr_err_b, rd_req_b, wr_en_b};
        if (hits[0] || hits[1]) begin
          checks++;
          if (hits[0] && hits[1]) begin
            errors++;
            $display("FAIL strobe_exclusive dut%0d: wr_en and rd_req both 1, required at most one", d);
          end
        end
        for (int k = 0; k < 5; k++) begin
          if (hits[k]) begin
            case (k)
              0:       ev = {EV_W, 1'b0, got_addr(d), got_wdata(d)};
              1:       ev = {EV_R, 1'b0, got_addr(d), 8'h00};
              default: ev = {4'(k + 1), 16'h0000};
            endcase
            checks++;
            if (pend(d) == 0) begin
              errors++;
              $display("FAIL unexpected_event dut%0d: got %h, required no event", d, ev);
            end else begin
              if (d == 0) e = exp_a.pop_front();
              else        e = exp_b.pop_front();
              if (ev !== e) begin
                errors++;
                $display("FAIL event_order dut%0d: got %h, required %h", d, ev, e);
              end else if (k == 3) begin
                lat = cyc - last_rise;
                checks++;
                if (lat <= TIMEOUT || lat > TIMEOUT + SYNC + 4) begin
                  errors++;
                  $display("FAIL timeout_latency dut%0d: %0d cycles after last sclk rise, required %0d..%0d",
                           d, lat, TIMEOUT + 1, TIMEOUT + SYNC + 4);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic push_ev(input int d, input logic [19:0] e);
    if (d == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  // Protocol model: first word = R/W + start address, later words write or advance-and-read.
  task automatic model_txn(input int d, input int n);
    int nr, a, start;
    bit wr, drop;
    nr = (d == 0) ? NR_A : NR_B;
    a = int'(m_addr[d]);
    wr = 1'b0;
    drop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (badp[i]) begin
        push_ev(d, {EV_P, 16'h0000});
        if (i == 0) drop = 1'b1;
      end else if (drop) begin
      end else if (i == 0) begin
        wr = words[0][7];
        start = int'(words[0][6:0]);
        if (start >= nr) begin
          push_ev(d, {EV_E, 16'h0000});
          drop = 1'b1;
        end else begin
          a = start;
          if (!wr) push_ev(d, {EV_R, 1'b0, 7'(a), 8'h00});
        end
      end else if (wr) begin
        push_ev(d, {EV_W, 1'b0, 7'(a), words[i]});
        m_wdata[d] = words[i];
        a = (a + 1) % nr;
      end else begin
        a = (a + 1) % nr;
        push_ev(d, {EV_R, 1'b0, 7'(a), 8'h00});
      end
    end
    push_ev(d, {EV_T, 16'h0000});
    m_addr[d] = 7'(a);
  endtask

  task automatic send_bit(input logic b);
    @(negedge iclk);
    sclk = 1'b0;
    serial_in = b;
    repeat ($urandom_range(1, 3)) @(negedge iclk);
    sclk = 1'b1;
    last_rise = cyc;
    repeat ($urandom_range(0, 2)) @(negedge iclk);
  endtask

  task automatic send_txn(input int n);
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) send_bit(words[i][b]);
`ifdef PICO_PARITY_EN
      send_bit((~^words[i]) ^ badp[i]);
`endif
    end
    @(negedge iclk);
    sclk = 1'b0;
  endtask

  task automatic model_both(input int n);
    exp_a.delete();
    exp_b.delete();
    model_txn(0, n);
    model_txn(1, n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge iclk);
    repeat (3) @(negedge iclk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge iclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_all(d) !== 21'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h, required 0", d, got_all(d));
      end
    end
    rst = 1'b0;
    m_addr = '{7'h00, 7'h00};
    m_wdata = '{8'h00, 8'h00};
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_write_burst();
    words[0] = 8'h85; words[1] = 8'hA5; words[2] = 8'h3C;
    badp = '{default: 1'b0};
    model_both(3);
    send_txn(3);
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL burst_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL burst_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
      checks++; if (got_wdata(d) !== m_wdata[d]) begin errors++; $display("FAIL burst_wdata dut%0d: got %h, required %h", d, got_wdata(d), m_wdata[d]); end
      checks++; if (got_busy(d) !== 1'b0) begin errors++; $display("FAIL burst_busy dut%0d: got %b, required 0", d, got_busy(d)); end
    end
    checks++;
    if (addr_a !== 7'h07 || wr_data_a !== 8'h3C) begin
      errors++;
      $display("FAIL burst_final dut0: addr %h data %h, required 07 3c", addr_a, wr_data_a);
    end
  endtask

  task automatic test_read();
    words[0] = 8'h10; words[1] = 8'h00;
    badp = '{default: 1'b0};
    model_both(2);
    send_txn(2);
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL read_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL read_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
      checks++; if (got_wdata(d) !== m_wdata[d]) begin errors++; $display("FAIL read_wdata dut%0d: got %h, required %h", d, got_wdata(d), m_wdata[d]); end
    end
  endtask

  task automatic test_wrap();
    words[0] = 8'hFF; words[1] = 8'h11; words[2] = 8'h22;
    badp = '{default: 1'b0};
    model_both(3);
    send_txn(3);
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL wrap_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL wrap_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
      checks++; if (got_wdata(d) !== m_wdata[d]) begin errors++; $display("FAIL wrap_wdata dut%0d: got %h, required %h", d, got_wdata(d), m_wdata[d]); end
    end
  endtask

  task automatic test_invalid_addr();
    words[0] = 8'hC8; words[1] = 8'h55;
    badp = '{default: 1'b0};
    model_both(2);
    send_txn(2);
    checks++;
    if (busy_b !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy dut1: got %b, required 1 while dropping", busy_b);
    end
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL inval_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL inval_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
      checks++; if (got_busy(d) !== 1'b0) begin errors++; $display("FAIL inval_busy dut%0d: got %b, required 0", d, got_busy(d)); end
    end
  endtask

  task automatic test_abort();
    model_both(0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    @(negedge iclk);
    sclk = 1'b0;
    wait_drain();
    words[0] = 8'h82; words[1] = 8'h99;
    badp = '{default: 1'b0};
    model_both(2);
    send_txn(2);
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL abort_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL abort_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
      checks++; if (got_wdata(d) !== m_wdata[d]) begin errors++; $display("FAIL abort_wdata dut%0d: got %h, required %h", d, got_wdata(d), m_wdata[d]); end
    end
    exp_a.delete();
    exp_b.delete();
    for (int b = 7; b >= 0; b--) send_bit(words[0][b]);
`ifdef PICO_PARITY_EN
    send_bit(~^words[0]);
`endif
    for (int b = 7; b >= 5; b--) send_bit(words[1][b]);
    @(negedge iclk);
    sclk = 1'b0;
    @(negedge iclk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midword_busy dut0: got %b, required 1", busy_a);
    end
    rst = 1'b1;
    @(negedge iclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_all(d) !== 21'h0) begin
        errors++;
        $display("FAIL midword_reset dut%0d: got %h, required 0", d, got_all(d));
      end
    end
    rst = 1'b0;
    m_addr = '{7'h00, 7'h00};
    m_wdata = '{8'h00, 8'h00};
    repeat (20) @(negedge iclk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) begin
        words[i] = 8'($urandom_range(0, 255));
`ifdef PICO_PARITY_EN
        badp[i] = ($urandom_range(0, 4) == 0);
`else
        badp[i] = 1'b0;
`endif
      end
      model_both(n);
      send_txn(n);
      wait_drain();
      for (int d = 0; d < 2; d++) begin
        checks++; if (pend(d) != 0) begin errors++; $display("FAIL rand%0d_events dut%0d: %0d outstanding, required 0", t, d, pend(d)); end
        checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL rand%0d_addr dut%0d: got %h, required %h", t, d, got_addr(d), m_addr[d]); end
        checks++; if (got_wdata(d) !== m_wdata[d]) begin errors++; $display("FAIL rand%0d_wdata dut%0d: got %h, required %h", t, d, got_wdata(d), m_wdata[d]); end
        checks++; if (got_busy(d) !== 1'b0) begin errors++; $display("FAIL rand%0d_busy dut%0d: got %b, required 0", t, d, got_busy(d)); end
      end
    end
  endtask

`ifdef PICO_PARITY_EN
  task automatic test_parity();
    words[0] = 8'h85; words[1] = 8'hA5; words[2] = 8'h3C;
    badp = '{default: 1'b0};
    badp[0] = 1'b1;
    model_both(3);
    send_txn(3);
    wait_drain();
    badp[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL parity_bad_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL parity_bad_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
    end
    model_both(3);
    send_txn(3);
    wait_drain();
    for (int d = 0; d < 2; d++) begin
      checks++; if (pend(d) != 0) begin errors++; $display("FAIL parity_ok_events dut%0d: %0d outstanding, required 0", d, pend(d)); end
      checks++; if (got_addr(d) !== m_addr[d]) begin errors++; $display("FAIL parity_ok_addr dut%0d: got %h, required %h", d, got_addr(d), m_addr[d]); end
      checks++; if (got_wdata(d) !== m_wdata[d]) begin errors++; $display("FAIL parity_ok_wdata dut%0d: got %h, required %h", d, got_wdata(d), m_wdata[d]); end
    end
  endtask
`endif

  initial begin
    badp = '{default: 1'b0};
    test_reset();
    test_write_burst();
    test_read();
    test_wrap();
    test_invalid_addr();
    test_abort();
    test_random();
`ifdef PICO_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
